disp_chan_mux: RTL and testbench
================================

# disp_chan_mux

Parametrised display-source selector for the seven-segment front end. Multiplexes a CPU-written channel 0 and NCH-1 live debug channels, each with data, decimal-point and blink masks, onto one registered display bus. Two modes: manual (switch-selected channel) and auto-scan (advances through all channels after a programmable dwell). Sits between the CPU/debug taps and the display scanner.

## Interface
- NCH, 8: number of channels (≥2)
- DW, 32: display data width per channel
- DIGITS, 8: digits per channel; width of point/blink masks
- SELW, 3: channel index width, ≥ clog2(NCH)
- DWW, 16: dwell counter width
- INIT_DATA, 32'hAA5555AA: reset value of channel-0 data and disp_num (low DW bits)
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- wr_en  in  1  capture cpu_data, point_in/blink_in slice 0 into channel-0 registers
- cpu_data  in  DW  channel-0 data source
- data_in  in  NCH*DW  live channel data; slice k = channel k (slice 0 unused)
- point_in  in  NCH*DIGITS  decimal-point masks; slice k = channel k
- blink_in  in  NCH*DIGITS  blink masks; slice k = channel k
- sel  in  SELW  manual channel select
- auto_en  in  1  1 = auto-scan, 0 = manual
- dwell  in  DWW  cycles per channel in auto-scan; 0 treated as 1
- freeze  in  1  hold all display outputs, cur_ch and dwell count
- disp_num  out  DW  selected data
- point_out  out  DIGITS  selected point mask
- blink_out  out  DIGITS  selected blink mask
- cur_ch  out  SELW  channel currently driving outputs
- ch_change  out  1  one-cycle pulse when cur_ch changes

## Operation
- Channel-0 registers: c0_data, c0_point, c0_blink. On wr_en: c0_data←cpu_data, c0_point←point_in[DIGITS-1:0], c0_blink←blink_in[DIGITS-1:0]; otherwise hold. Reset: INIT_DATA, all zeros, all ones. wr_en is honoured regardless of freeze.
- Channels 1..NCH-1: data_in/point_in/blink_in slices sampled live.
- next_ch:
  - freeze=1: cur_ch.
  - manual: sel if sel<NCH, else cur_ch (out-of-range select ignored).
  - auto: if cnt = max(dwell,1)-1 then (cur_ch = NCH-1 ? 0 : cur_ch+1), else cur_ch.
- Dwell counter cnt (DWW bits): manual or freeze → manual clears to 0, freeze holds; auto → 0 when advancing, else cnt+1. dwell changed mid-count: compare uses new value; if cnt ≥ new limit-1, advance on that edge.
- Mode switch manual→auto: scan starts from current cur_ch with cnt=0. auto→manual: next_ch=sel on the first manual edge.
- Each edge (freeze=0): cur_ch←next_ch; disp_num/point_out/blink_out←slice of channel next_ch (channel 0 uses registered c0_*). Outputs and cur_ch are always mutually consistent.
- freeze=1: disp_num/point_out/blink_out/cur_ch hold even if selected channel's live inputs change.
- ch_change←(next_ch ≠ cur_ch), registered.

## Timing
- Reset (async, immediate): cur_ch=0, cnt=0, ch_change=0, disp_num=INIT_DATA, point_out=0, blink_out=all ones, c0_* as above. Reset mid-scan abandons scan; first edge after release follows normal rules.
- sel change → outputs/cur_ch updated at next rising edge (1-cycle latency).
- Live channel input change → visible 1 cycle later while selected.
- wr_en at edge k with channel 0 selected: disp_num shows new value after edge k+1 (2-cycle write-to-display).
- Auto-scan: each channel held exactly max(dwell,1) cycles; dwell=1 advances every cycle; wrap NCH-1→0 with no extra cycle.
- ch_change high for exactly the cycle after cur_ch updates; never high while freeze=1.

## Test plan
- Reset, release, sel=0, no writes → disp_num=AA5555AA, point_out=00, blink_out=FF, cur_ch=0, ch_change=0.
- wr_en 1 cycle with cpu_data=12345678, point_in[7:0]=0F, blink_in[7:0]=F0 → disp_num=12345678, point_out=0F, blink_out=F0 two edges after the write edge.
- Manual sel=3, data_in slice 3=DEADBEEF → disp_num=DEADBEEF, cur_ch=3 one edge later, ch_change pulse 1 cycle; sel=9 (NCH=8) → cur_ch stays 3, no pulse.
- auto_en=1, dwell=4, from cur_ch=6 → cur_ch 6,7,0,1 each held 4 cycles, ch_change pulse each advance; dwell=0 → advance every cycle.
- Auto-scan running, freeze=1 for 10 cycles while slice data changes → outputs, cur_ch frozen, no pulses; freeze=0 → scan resumes with remaining dwell.
- Assert rst mid-scan at cur_ch=5 → outputs to reset values immediately without clock; after release with auto_en=1, scan restarts from 0.

Source files
------------

// File: rtl/disp_chan_mux.sv
// Display-source selector: picks one of NCH channels (channel 0 is CPU-written,
// the rest are live debug taps) in manual or auto-scan mode onto a registered bus.
module disp_chan_mux #(
    parameter int          NCH       = 8,
    parameter int          DW        = 32,
    parameter int          DIGITS    = 8,
    parameter int          SELW      = 3,
    parameter int          DWW       = 16,
    parameter logic [31:0] INIT_DATA = 32'hAA5555AA
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [DW-1:0]            cpu_data,
    input  logic [NCH*DW-1:0]        data_in,
    input  logic [NCH*DIGITS-1:0]    point_in,
    input  logic [NCH*DIGITS-1:0]    blink_in,
    input  logic [SELW-1:0]          sel,
    input  logic                     auto_en,
    input  logic [DWW-1:0]           dwell,
    input  logic                     freeze,
    output logic [DW-1:0]            disp_num,
    output logic [DIGITS-1:0]        point_out,
    output logic [DIGITS-1:0]        blink_out,
    output logic [SELW-1:0]          cur_ch,
    output logic                     ch_change
);

    logic [DW-1:0]     c0_data_q,  c0_data_d;
    logic [DIGITS-1:0] c0_point_q, c0_point_d;
    logic [DIGITS-1:0] c0_blink_q, c0_blink_d;
    logic [SELW-1:0]   cur_ch_q,   cur_ch_d;
    logic [DWW-1:0]    cnt_q,      cnt_d;
    logic              ch_change_q, ch_change_d;
    logic [DW-1:0]     disp_num_q, disp_num_d;
    logic [DIGITS-1:0] point_q,    point_d;
    logic [DIGITS-1:0] blink_q,    blink_d;

    logic [DW-1:0]     ch_data  [NCH];
    logic [DIGITS-1:0] ch_point [NCH];
    logic [DIGITS-1:0] ch_blink [NCH];

    logic [SELW-1:0]   next_ch;
    logic [DWW-1:0]    lim_m1;
    logic              sel_ok;
    logic [DW-1:0]     sel_data;
    logic [DIGITS-1:0] sel_point;
    logic [DIGITS-1:0] sel_blink;

    // Channel 0's data slice of data_in has no meaning; cpu_data feeds it instead.
    logic unused_slice0;
    assign unused_slice0 = ^data_in[DW-1:0];

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            if (gi == 0) begin : g_cpu
                assign ch_data[gi]  = c0_data_q;
                assign ch_point[gi] = c0_point_q;
                assign ch_blink[gi] = c0_blink_q;
            end else begin : g_live
                assign ch_data[gi]  = data_in[gi*DW +: DW];
                assign ch_point[gi] = point_in[gi*DIGITS +: DIGITS];
                assign ch_blink[gi] = blink_in[gi*DIGITS +: DIGITS];
            end
        end
    endgenerate

    always_comb begin
        c0_data_d  = c0_data_q;
        c0_point_d = c0_point_q;
        c0_blink_d = c0_blink_q;
        if (wr_en) begin
            c0_data_d  = cpu_data;
            c0_point_d = point_in[DIGITS-1:0];
            c0_blink_d = blink_in[DIGITS-1:0];
        end
    end

    // A dwell of zero behaves as one; ">=" lets a shortened dwell take effect at once.
    always_comb begin
        lim_m1  = (dwell == '0) ? '0 : dwell - DWW'(1);
        sel_ok  = {1'b0, sel} < (SELW+1)'(NCH);
        next_ch = cur_ch_q;
        cnt_d   = cnt_q;
        if (!freeze) begin
            if (!auto_en) begin
                cnt_d = '0;
                if (sel_ok) next_ch = sel;
            end else if (cnt_q >= lim_m1) begin
                cnt_d   = '0;
                next_ch = (cur_ch_q == SELW'(NCH-1)) ? '0 : cur_ch_q + SELW'(1);
            end else begin
                cnt_d = cnt_q + DWW'(1);
            end
        end
    end

    always_comb begin
        sel_data  = ch_data[0];
        sel_point = ch_point[0];
        sel_blink = ch_blink[0];
        for (int i = 1; i < NCH; i++) begin
            if (next_ch == SELW'(i)) begin
                sel_data  = ch_data[i];
                sel_point = ch_point[i];
                sel_blink = ch_blink[i];
            end
        end
    end

    always_comb begin
        cur_ch_d    = cur_ch_q;
        disp_num_d  = disp_num_q;
        point_d     = point_q;
        blink_d     = blink_q;
        ch_change_d = (next_ch != cur_ch_q);
        if (!freeze) begin
            cur_ch_d   = next_ch;
            disp_num_d = sel_data;
            point_d    = sel_point;
            blink_d    = sel_blink;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c0_data_q   <= DW'(INIT_DATA);
            c0_point_q  <= '0;
            c0_blink_q  <= '1;
            cur_ch_q    <= '0;
            cnt_q       <= '0;
            ch_change_q <= 1'b0;
            disp_num_q  <= DW'(INIT_DATA);
            point_q     <= '0;
            blink_q     <= '1;
        end else begin
            c0_data_q   <= c0_data_d;
            c0_point_q  <= c0_point_d;
            c0_blink_q  <= c0_blink_d;
            cur_ch_q    <= cur_ch_d;
            cnt_q       <= cnt_d;
            ch_change_q <= ch_change_d;
            disp_num_q  <= disp_num_d;
            point_q     <= point_d;
            blink_q     <= blink_d;
        end
    end

    assign disp_num  = disp_num_q;
    assign point_out = point_q;
    assign blink_out = blink_q;
    assign cur_ch    = cur_ch_q;
    assign ch_change = ch_change_q;

endmodule

// File: tb/tb_disp_chan_mux.sv
// Bench for disp_chan_mux: behavioural model checked every cycle plus directed
// literal expectations for reset, CPU write, manual select, auto-scan, freeze and reset.
module tb_disp_chan_mux;

    localparam int NCH = 8;
    localparam int DW = 32;
    localparam int DIGITS = 8;
    localparam int SELW = 4;
    localparam int DWW = 16;
    localparam logic [31:0] INIT = 32'hAA5555AA;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic                   wr_en = 1'b0;
    logic [DW-1:0]          cpu_data = '0;
    logic [NCH*DW-1:0]      data_in = '0;
    logic [NCH*DIGITS-1:0]  point_in = '0;
    logic [NCH*DIGITS-1:0]  blink_in = '0;
    logic [SELW-1:0]        sel = '0;
    logic                   auto_en = 1'b0;
    logic [DWW-1:0]         dwell = '0;
    logic                   freeze = 1'b0;
    logic [DW-1:0]          disp_num;
    logic [DIGITS-1:0]      point_out;
    logic [DIGITS-1:0]      blink_out;
    logic [SELW-1:0]        cur_ch;
    logic                   ch_change;

    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;

    disp_chan_mux #(
        .NCH(NCH), .DW(DW), .DIGITS(DIGITS), .SELW(SELW), .DWW(DWW), .INIT_DATA(INIT)
    ) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .cpu_data(cpu_data),
        .data_in(data_in), .point_in(point_in), .blink_in(blink_in),
        .sel(sel), .auto_en(auto_en), .dwell(dwell), .freeze(freeze),
        .disp_num(disp_num), .point_out(point_out), .blink_out(blink_out),
        .cur_ch(cur_ch), .ch_change(ch_change)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: which channel is shown and how many auto-scan cycles it has been shown.
    int          m_ch, m_held;
    logic        m_chg;
    logic [31:0] m_disp;
    logic [7:0]  m_pt, m_bl;
    logic [31:0] m_c0d;
    logic [7:0]  m_c0p, m_c0b;

    function automatic int limit();
        return (dwell == 0) ? 1 : int'(dwell);
    endfunction

    function automatic bit auto_adv();
        return !freeze && auto_en && (m_held + 1 >= limit());
    endfunction

    function automatic int model_next();
        if (freeze) return m_ch;
        if (!auto_en) return (int'(sel) < NCH) ? int'(sel) : m_ch;
        if (auto_adv()) return (m_ch + 1) % NCH;
        return m_ch;
    endfunction

    function automatic logic [31:0] ch_data(input int c);
        return (c == 0) ? m_c0d : data_in[c*DW +: DW];
    endfunction
    function automatic logic [7:0] ch_pt(input int c);
        return (c == 0) ? m_c0p : point_in[c*DIGITS +: DIGITS];
    endfunction
    function automatic logic [7:0] ch_bl(input int c);
        return (c == 0) ? m_c0b : blink_in[c*DIGITS +: DIGITS];
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ch <= 0; m_held <= 0; m_chg <= 1'b0;
            m_disp <= INIT; m_pt <= 8'h00; m_bl <= 8'hFF;
            m_c0d <= INIT; m_c0p <= 8'h00; m_c0b <= 8'hFF;
        end else begin
            if (wr_en) begin
                m_c0d <= cpu_data;
                m_c0p <= point_in[7:0];
                m_c0b <= blink_in[7:0];
            end
            if (freeze) begin
                m_chg <= 1'b0;
            end else begin
                m_held <= (!auto_en || auto_adv()) ? 0 : m_held + 1;
                m_ch   <= model_next();
                m_chg  <= (model_next() != m_ch);
                m_disp <= ch_data(model_next());
                m_pt   <= ch_pt(model_next());
                m_bl   <= ch_bl(model_next());
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("m_disp_num", disp_num, m_disp);
            check("m_point_out", point_out, m_pt);
            check("m_blink_out", blink_out, m_bl);
            check("m_cur_ch", cur_ch, m_ch);
            check("m_ch_change", ch_change, m_chg);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    int seq [16] = '{6,6,6,6, 7,7,7,7, 0,0,0,0, 1,1,1,1};
    int prev, fc, found;
    logic [31:0] fd;

    initial begin
        #1 rst = 1'b1;
        chk_en = 1'b1;
        tick(); tick();
        #2 rst = 1'b0;
        tick(); tick();
        check("rst_disp", disp_num, 32'hAA5555AA);
        check("rst_point", point_out, 32'h00);
        check("rst_blink", blink_out, 32'hFF);
        check("rst_cur_ch", cur_ch, 32'd0);
        check("rst_ch_change", ch_change, 32'd0);

        // CPU write into channel 0: visible two edges after the write edge
        wr_en = 1'b1; cpu_data = 32'h12345678;
        point_in[7:0] = 8'h0F; blink_in[7:0] = 8'hF0;
        tick();
        wr_en = 1'b0; point_in[7:0] = 8'h33; blink_in[7:0] = 8'h44;
        check("wr_edge_k_disp", disp_num, 32'hAA5555AA);
        tick();
        check("wr_disp", disp_num, 32'h12345678);
        check("wr_point", point_out, 32'h0F);
        check("wr_blink", blink_out, 32'hF0);

        // Manual select of a live channel
        data_in[3*DW +: DW] = 32'hDEADBEEF;
        point_in[3*DIGITS +: DIGITS] = 8'hA5;
        blink_in[3*DIGITS +: DIGITS] = 8'h5A;
        sel = 4'd3;
        tick();
        check("sel3_disp", disp_num, 32'hDEADBEEF);
        check("sel3_point", point_out, 32'hA5);
        check("sel3_cur_ch", cur_ch, 32'd3);
        check("sel3_pulse", ch_change, 32'd1);
        data_in[3*DW +: DW] = 32'hCAFEF00D;
        tick();
        check("sel3_pulse_end", ch_change, 32'd0);
        check("live_update", disp_num, 32'hCAFEF00D);
        sel = 4'd9;
        tick();
        check("sel9_cur_ch", cur_ch, 32'd3);
        check("sel9_no_pulse", ch_change, 32'd0);
        tick();
        check("sel9_cur_ch2", cur_ch, 32'd3);

        // Auto-scan from channel 6 with dwell 4
        for (int k = 1; k < NCH; k++) data_in[k*DW +: DW] = 32'h1000_0000 * k + k;
        sel = 4'd6;
        tick(); tick();
        auto_en = 1'b1; dwell = 16'd4;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("scan4_%0d", i), cur_ch, seq[i]);
            if (i == 4 || i == 8) check($sformatf("scan4_pulse_%0d", i), ch_change, 32'd1);
            tick();
        end

        // Dwell 0 behaves as 1: advance on every edge
        dwell = 16'd0;
        for (int i = 0; i < 4; i++) begin
            prev = int'(cur_ch);
            tick();
            check("dwell0_step", cur_ch, (prev + 1) % NCH);
        end

        // Freeze while live data changes
        dwell = 16'd4;
        tick(); tick();
        freeze = 1'b1;
        tick();
        fc = int'(cur_ch); fd = disp_num;
        for (int i = 0; i < 10; i++) begin
            for (int k = 1; k < NCH; k++) data_in[k*DW +: DW] = $urandom;
            tick();
            check("frz_cur_ch", cur_ch, fc);
            check("frz_disp", disp_num, fd);
            check("frz_no_pulse", ch_change, 32'd0);
        end
        freeze = 1'b0;
        for (int i = 0; i < 10; i++) tick();

        // Asynchronous reset while channel 5 is on display
        found = 0;
        for (int i = 0; i < 64 && found == 0; i++) begin
            if (cur_ch == 4'd5) found = 1;
            else tick();
        end
        check("reach_ch5", found, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_disp", disp_num, 32'hAA5555AA);
        check("arst_point", point_out, 32'h00);
        check("arst_blink", blink_out, 32'hFF);
        check("arst_cur_ch", cur_ch, 32'd0);
        check("arst_pulse", ch_change, 32'd0);
        tick();
        #2 rst = 1'b0; dwell = 16'd2;
        #1 check("post_rst_0", cur_ch, 32'd0);
        tick(); check("post_rst_1", cur_ch, 32'd0);
        tick(); check("post_rst_2", cur_ch, 32'd1);
        tick(); check("post_rst_3", cur_ch, 32'd1);
        tick(); check("post_rst_4", cur_ch, 32'd2);
        tick();

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
